// File: rtl/fractal_iter_engine.sv
// Single-lane escape-time fractal engine: iterates z <- z^2 + c once per clock in Mandelbrot or Julia mode.
// Optional feature macro ITER_COUNT_OUT_EN exposes the final iteration count on oIterCount.
module fractal_iter_engine #(
    parameter int WIDTH   = 36,
    parameter int FRAC    = 33,
    parameter int ITER_W  = 12,
    parameter int COLOR_W = 4,
    parameter int VGAX_W  = 10,
    parameter int VGAY_W  = 9
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      iDataVal,
    input  logic signed [WIDTH-1:0]   iCoordX,
    input  logic signed [WIDTH-1:0]   iCoordY,
    input  logic [VGAX_W-1:0]         iVGAX,
    input  logic [VGAY_W-1:0]         iVGAY,
    input  logic                      iMode,
    input  logic signed [WIDTH-1:0]   iJuliaRe,
    input  logic signed [WIDTH-1:0]   iJuliaIm,
    input  logic [ITER_W-1:0]         iMaxIter,
    output logic                      oProcReady,
    input  logic                      valueStored,
    output logic [COLOR_W-1:0]        oColor,
    output logic [VGAX_W+VGAY_W-1:0]  oVGACoord,
    output logic                      oVGAVal
`ifdef ITER_COUNT_OUT_EN
    ,
    output logic [ITER_W-1:0]         oIterCount
`endif
);

    // Four guard bits: |z|^2 reaches 32.0 when z = (-4,-4), and 2*zr*zi + ci reaches ~36.0.
    localparam int EXT = WIDTH + 4;
    localparam int PW  = 2 * WIDTH;

    localparam logic signed [EXT-1:0] ESC_LIM = EXT'(4) << FRAC;
    localparam logic signed [EXT-1:0] SAT_MAX = {{(EXT-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [EXT-1:0] SAT_MIN = {{(EXT-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic signed [WIDTH-1:0]    zr_q, zr_d, zi_q, zi_d;
    logic signed [WIDTH-1:0]    cr_q, cr_d, ci_q, ci_d;
    logic [ITER_W-1:0]          count_q, count_d;
    logic [ITER_W-1:0]          max_iter_q, max_iter_d;
    logic [COLOR_W-1:0]         color_q, color_d;
    logic [VGAX_W+VGAY_W-1:0]   coord_q, coord_d;
    logic                       val_q, val_d;
`ifdef ITER_COUNT_OUT_EN
    logic [ITER_W-1:0]          iter_cnt_q, iter_cnt_d;
`endif

    logic signed [PW-1:0]       zr_w, zi_w, p_rr, p_ii, p_ri;
    logic signed [EXT-1:0]      sq_rr, sq_ii, sq_ri, mag, nr, ni;
    logic                       escape;

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [EXT-1:0] v);
        if (v > SAT_MAX) return WIDTH'(SAT_MAX);
        if (v < SAT_MIN) return WIDTH'(SAT_MIN);
        return WIDTH'(v);
    endfunction

    // Colour is the index of the highest set bit of the count, clamped to the colour range.
    function automatic logic [COLOR_W-1:0] log2_color(input logic [ITER_W-1:0] cnt);
        int msb;
        msb = 0;
        for (int b = 1; b < ITER_W; b++) begin
            if (cnt[b]) msb = b;
        end
        if (msb > (2**COLOR_W) - 1) return {COLOR_W{1'b1}};
        return COLOR_W'(msb);
    endfunction

    always_comb begin
        zr_w   = {{WIDTH{zr_q[WIDTH-1]}}, zr_q};
        zi_w   = {{WIDTH{zi_q[WIDTH-1]}}, zi_q};
        p_rr   = zr_w * zr_w;
        p_ii   = zi_w * zi_w;
        p_ri   = zr_w * zi_w;
        sq_rr  = EXT'(p_rr >>> FRAC);
        sq_ii  = EXT'(p_ii >>> FRAC);
        sq_ri  = EXT'(p_ri >>> FRAC);
        mag    = sq_rr + sq_ii;
        escape = (mag > ESC_LIM);
        nr     = sq_rr - sq_ii + EXT'(cr_q);
        ni     = (sq_ri <<< 1) + EXT'(ci_q);
    end

    always_comb begin
        state_d    = state_q;
        zr_d       = zr_q;
        zi_d       = zi_q;
        cr_d       = cr_q;
        ci_d       = ci_q;
        count_d    = count_q;
        max_iter_d = max_iter_q;
        color_d    = color_q;
        coord_d    = coord_q;
        val_d      = val_q;
`ifdef ITER_COUNT_OUT_EN
        iter_cnt_d = iter_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (iDataVal) begin
                    state_d    = ITER;
                    count_d    = '0;
                    max_iter_d = iMaxIter;
                    coord_d    = {iVGAX, iVGAY};
                    if (iMode) begin
                        zr_d = iCoordX;
                        zi_d = iCoordY;
                        cr_d = iJuliaRe;
                        ci_d = iJuliaIm;
                    end else begin
                        zr_d = '0;
                        zi_d = '0;
                        cr_d = iCoordX;
                        ci_d = iCoordY;
                    end
                end
            end
            ITER: begin
                if (escape) begin
                    state_d = DONE;
                    color_d = log2_color(count_q);
`ifdef ITER_COUNT_OUT_EN
                    iter_cnt_d = count_q;
`endif
                end else if (count_q == max_iter_q) begin
                    state_d = DONE;
                    color_d = '0;
`ifdef ITER_COUNT_OUT_EN
                    iter_cnt_d = count_q;
`endif
                end else begin
                    zr_d    = sat(nr);
                    zi_d    = sat(ni);
                    count_d = count_q + ITER_W'(1);
                end
            end
            DONE: begin
                // Result is presented one cycle after entering DONE; the ack only counts once it is visible.
                if (!val_q) begin
                    val_d = 1'b1;
                end else if (valueStored) begin
                    val_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            zr_q       <= '0;
            zi_q       <= '0;
            cr_q       <= '0;
            ci_q       <= '0;
            count_q    <= '0;
            max_iter_q <= '0;
            color_q    <= '0;
            coord_q    <= '0;
            val_q      <= 1'b0;
`ifdef ITER_COUNT_OUT_EN
            iter_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            zr_q       <= zr_d;
            zi_q       <= zi_d;
            cr_q       <= cr_d;
            ci_q       <= ci_d;
            count_q    <= count_d;
            max_iter_q <= max_iter_d;
            color_q    <= color_d;
            coord_q    <= coord_d;
            val_q      <= val_d;
`ifdef ITER_COUNT_OUT_EN
            iter_cnt_q <= iter_cnt_d;
`endif
        end
    end

    assign oProcReady = (state_q == IDLE);
    assign oColor     = color_q;
    assign oVGACoord  = coord_q;
    assign oVGAVal    = val_q;
`ifdef ITER_COUNT_OUT_EN
    assign oIterCount = iter_cnt_q;
`endif

endmodule

// File: tb/tb_fractal_iter_engine.sv
// Scoreboard bench for fractal_iter_engine: expected results come from a wide-precision loop model.
module tb_fractal_iter_engine;

    localparam int W = 36;
    localparam int F = 33;
    localparam logic signed [W-1:0] ONE = 36'sd1 <<< F;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic iDataVal = 1'b0;
    logic signed [W-1:0] iCoordX = '0, iCoordY = '0, iJuliaRe = '0, iJuliaIm = '0;
    logic [9:0]  iVGAX = '0;
    logic [8:0]  iVGAY = '0;
    logic        iMode = 1'b0;
    logic [11:0] iMaxIter = '0;
    logic        valueStored = 1'b0;
    logic        oProcReady;
    logic [3:0]  oColor;
    logic [18:0] oVGACoord;
    logic        oVGAVal;
`ifdef ITER_COUNT_OUT_EN
    logic [11:0] oIterCount;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  col;
        logic [18:0] coord;
        int          lat;
        logic [11:0] cnt;
    } exp_t;
    exp_t sb[$];

    fractal_iter_engine dut (
        .clk(clk), .reset(reset), .iDataVal(iDataVal),
        .iCoordX(iCoordX), .iCoordY(iCoordY), .iVGAX(iVGAX), .iVGAY(iVGAY),
        .iMode(iMode), .iJuliaRe(iJuliaRe), .iJuliaIm(iJuliaIm), .iMaxIter(iMaxIter),
        .oProcReady(oProcReady), .valueStored(valueStored),
        .oColor(oColor), .oVGACoord(oVGACoord), .oVGAVal(oVGAVal)
`ifdef ITER_COUNT_OUT_EN
        , .oIterCount(oIterCount)
`endif
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic mode, input logic signed [W-1:0] cx, cy, jr, ji,
                                   input logic [11:0] mi, input logic [9:0] x, input logic [8:0] y);
        logic signed [79:0] zr, zi, cr, ci, rr, ii, ri, mag, nr, ni, lim, hi, lo;
        exp_t e;
        int n, l, v;
        lim = 80'sd4 <<< F;
        hi  = (80'sd1 <<< (W-1)) - 80'sd1;
        lo  = -(80'sd1 <<< (W-1));
        if (mode) begin zr = cx; zi = cy; cr = jr; ci = ji; end
        else      begin zr = 0;  zi = 0;  cr = cx; ci = cy; end
        e.coord = {x, y};
        e.col = 4'd0;
        n = 0;
        forever begin
            rr = (zr * zr) >>> F;
            ii = (zi * zi) >>> F;
            ri = (zr * zi) >>> F;
            mag = rr + ii;
            if (mag > lim) begin
                l = 0; v = n;
                while (v > 1) begin v = v >> 1; l++; end
                if (l > 15) l = 15;
                e.col = 4'(l);
                break;
            end
            if (n == int'(mi)) break;
            nr = rr - ii + cr;
            ni = 2 * ri + ci;
            zr = (nr > hi) ? hi : ((nr < lo) ? lo : nr);
            zi = (ni > hi) ? hi : ((ni < lo) ? lo : ni);
            n++;
        end
        e.lat = n + 2;
        e.cnt = 12'(n);
        return e;
    endfunction

    task automatic set_pix(input logic mode, input logic signed [W-1:0] cx, cy, jr, ji,
                           input logic [11:0] mi, input logic [9:0] x, input logic [8:0] y);
        iMode = mode; iCoordX = cx; iCoordY = cy; iJuliaRe = jr; iJuliaIm = ji;
        iMaxIter = mi; iVGAX = x; iVGAY = y;
        sb.push_back(model(mode, cx, cy, jr, ji, mi, x, y));
    endtask

    // Accept on the next edge, then scramble inputs that must not affect the pixel in flight.
    task automatic accept();
        iDataVal = 1'b1;
        @(posedge clk); #1;
        iDataVal = 1'b0;
        iMode = ~iMode; iJuliaRe = ONE; iJuliaIm = -ONE; iMaxIter = 12'd7;
        iCoordX = 36'sd12345; iCoordY = -36'sd999;
    endtask

    task automatic wait_result(output int lat, output logic [11:0] cnt);
        lat = -1;
        cnt = '0;
        for (int k = 1; k <= 6000; k++) begin
            @(posedge clk); #1;
            if (oVGAVal) begin lat = k; break; end
        end
`ifdef ITER_COUNT_OUT_EN
        cnt = oIterCount;
`endif
    endtask

    task automatic ack();
        valueStored = 1'b1;
        @(posedge clk); #1;
        valueStored = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks += 4;
        if (oProcReady !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", oProcReady); end
        if (oVGAVal !== 1'b0)    begin failures++; $display("FAIL reset_val: got %b expected 0", oVGAVal); end
        if (oColor !== 4'd0)     begin failures++; $display("FAIL reset_color: got %0d expected 0", oColor); end
        if (oVGACoord !== 19'd0) begin failures++; $display("FAIL reset_coord: got %h expected 0", oVGACoord); end
        reset = 1'b0;
        $display("test_reset: ready=%b val=%b", oProcReady, oVGAVal);
    endtask

    task automatic test_mandel_limit();
        int lat; logic [11:0] cnt; exp_t e;
        set_pix(1'b0, 0, 0, 0, 0, 12'd100, 10'd5, 9'd7);
        accept();
        checks++;
        if (oProcReady !== 1'b0) begin failures++; $display("FAIL busy_after_accept: got %b expected 0", oProcReady); end
        wait_result(lat, cnt);
        e = sb.pop_front();
        checks += 3;
        if (lat !== e.lat)         begin failures++; $display("FAIL limit_lat: got %0d expected %0d", lat, e.lat); end
        if (oColor !== e.col)      begin failures++; $display("FAIL limit_color: got %0d expected %0d", oColor, e.col); end
        if (oVGACoord !== e.coord) begin failures++; $display("FAIL limit_coord: got %h expected %h", oVGACoord, e.coord); end
        $display("test_mandel_limit: lat=%0d color=%0d coord=%h", lat, oColor, oVGACoord);
        ack();
    endtask

    task automatic test_mandel_escape();
        int lat; logic [11:0] cnt; exp_t e;
        set_pix(1'b0, ONE, ONE, 0, 0, 12'd100, 10'd639, 9'd479);
        accept();
        wait_result(lat, cnt);
        e = sb.pop_front();
        checks += 3;
        if (lat !== 4 || e.lat !== 4) begin failures++; $display("FAIL esc_lat: got %0d expected 4", lat); end
        if (oColor !== 4'd1)          begin failures++; $display("FAIL esc_color: got %0d expected 1", oColor); end
        if (oVGACoord !== e.coord)    begin failures++; $display("FAIL esc_coord: got %h expected %h", oVGACoord, e.coord); end
        $display("test_mandel_escape: lat=%0d color=%0d", lat, oColor);
        ack();
    endtask

    task automatic test_julia_iter0();
        int lat; logic [11:0] cnt; exp_t e;
        logic signed [W-1:0] re_tab [3];
        re_tab[0] = 3 * ONE;
        re_tab[1] = ONE / 2;
        re_tab[2] = -(4 * ONE);
        for (int i = 0; i < 3; i++) begin
            set_pix(1'b1, re_tab[i], (i == 2) ? -(4 * ONE) : 36'sd0, ONE / 4, ONE / 4, 12'd0, 10'(i), 9'(i + 1));
            accept();
            wait_result(lat, cnt);
            e = sb.pop_front();
            checks += 3;
            if (lat !== 2 || e.lat !== 2) begin failures++; $display("FAIL julia0_lat[%0d]: got %0d expected 2", i, lat); end
            if (oColor !== e.col)      begin failures++; $display("FAIL julia0_color[%0d]: got %0d expected %0d", i, oColor, e.col); end
            if (oVGACoord !== e.coord) begin failures++; $display("FAIL julia0_coord[%0d]: got %h expected %h", i, oVGACoord, e.coord); end
            $display("test_julia_iter0[%0d]: lat=%0d color=%0d", i, lat, oColor);
            ack();
        end
    endtask

    task automatic test_hold_ack();
        int lat; logic [11:0] cnt; exp_t e;
        set_pix(1'b0, ONE / 2, ONE / 2, 0, 0, 12'd20, 10'd100, 9'd200);
        accept();
        wait_result(lat, cnt);
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat) begin failures++; $display("FAIL hold_lat: got %0d expected %0d", lat, e.lat); end
        // Second pixel offered while the first is held; it must not be taken until the ack.
        set_pix(1'b0, -ONE, 0, 0, 0, 12'd9, 10'd1, 9'd2);
        iDataVal = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            checks++;
            if (oVGAVal !== 1'b1 || oColor !== e.col || oVGACoord !== e.coord || oProcReady !== 1'b0) begin
                failures++;
                $display("FAIL hold_stable[%0d]: got val=%b col=%0d coord=%h rdy=%b expected val=1 col=%0d coord=%h rdy=0",
                         k, oVGAVal, oColor, oVGACoord, oProcReady, e.col, e.coord);
            end
        end
        valueStored = 1'b1;
        @(posedge clk); #1;
        valueStored = 1'b0;
        checks += 2;
        if (oVGAVal !== 1'b0)    begin failures++; $display("FAIL ack_val: got %b expected 0", oVGAVal); end
        if (oProcReady !== 1'b1) begin failures++; $display("FAIL ack_ready: got %b expected 1", oProcReady); end
        @(posedge clk); #1;
        iDataVal = 1'b0;
        checks++;
        if (oProcReady !== 1'b0) begin failures++; $display("FAIL b2b_accept: got ready=%b expected 0", oProcReady); end
        wait_result(lat, cnt);
        e = sb.pop_front();
        checks += 3;
        if (lat !== e.lat)         begin failures++; $display("FAIL b2b_lat: got %0d expected %0d", lat, e.lat); end
        if (oColor !== e.col)      begin failures++; $display("FAIL b2b_color: got %0d expected %0d", oColor, e.col); end
        if (oVGACoord !== e.coord) begin failures++; $display("FAIL b2b_coord: got %h expected %h", oVGACoord, e.coord); end
        $display("test_hold_ack: second pixel lat=%0d color=%0d", lat, oColor);
        ack();
    endtask

    task automatic test_saturation();
        int lat; logic [11:0] cnt; exp_t e;
        logic signed [W-1:0] big;
        big = 2 * ONE - ONE / 1000;
        set_pix(1'b0, -big, big, 0, 0, 12'd4095, 10'd3, 9'd4);
        accept();
        wait_result(lat, cnt);
        e = sb.pop_front();
        checks += 2;
        if (lat !== e.lat || lat < 3 || lat > 4) begin failures++; $display("FAIL sat_lat: got %0d expected %0d", lat, e.lat); end
        if (oColor !== e.col) begin failures++; $display("FAIL sat_color: got %0d expected %0d", oColor, e.col); end
        $display("test_saturation: lat=%0d color=%0d", lat, oColor);
        ack();
    endtask

    task automatic test_random();
        int lat; logic [11:0] cnt; exp_t e;
        logic signed [W-1:0] rx, ry, jr, ji;
        logic [63:0] r;
        for (int i = 0; i < 200; i++) begin
            r = {$urandom(), $urandom()}; rx = W'(r);
            r = {$urandom(), $urandom()}; ry = W'(r);
            r = {$urandom(), $urandom()}; jr = W'(r) >>> 2;
            r = {$urandom(), $urandom()}; ji = W'(r) >>> 2;
            if ($urandom_range(0, 1) == 1) begin rx = rx >>> 2; ry = ry >>> 2; end
            set_pix(1'($urandom_range(0, 1)), rx, ry, jr, ji, 12'($urandom_range(0, 60)),
                    10'($urandom_range(0, 639)), 9'($urandom_range(0, 479)));
            accept();
            wait_result(lat, cnt);
            e = sb.pop_front();
            checks++;
            if (lat !== e.lat || oColor !== e.col || oVGACoord !== e.coord) begin
                failures++;
                $display("FAIL rand[%0d]: got lat=%0d col=%0d coord=%h expected lat=%0d col=%0d coord=%h",
                         i, lat, oColor, oVGACoord, e.lat, e.col, e.coord);
            end
`ifdef ITER_COUNT_OUT_EN
            checks++;
            if (cnt !== e.cnt) begin failures++; $display("FAIL rand_cnt[%0d]: got %0d expected %0d", i, cnt, e.cnt); end
`endif
            $display("test_random[%0d]: lat=%0d color=%0d", i, lat, oColor);
            ack();
        end
    endtask

    task automatic test_reset_abort();
        int seen;
        set_pix(1'b0, 0, 0, 0, 0, 12'd100, 10'd9, 9'd9);
        accept();
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        checks += 2;
        if (oVGAVal !== 1'b0)    begin failures++; $display("FAIL abort_val: got %b expected 0", oVGAVal); end
        if (oProcReady !== 1'b1) begin failures++; $display("FAIL abort_ready: got %b expected 1", oProcReady); end
        seen = 0;
        repeat (120) begin
            @(posedge clk); #1;
            if (oVGAVal) seen++;
        end
        checks++;
        if (seen !== 0) begin failures++; $display("FAIL abort_no_output: got %0d valid cycles expected 0", seen); end
        $display("test_reset_abort: valid cycles after abort=%0d", seen);
    endtask

    initial begin
        test_reset();
        test_mandel_limit();
        test_mandel_escape();
        test_julia_iter0();
        test_hold_ack();
        test_saturation();
        test_random();
        test_reset_abort();
        checks++;
        if (sb.size() !== 0) begin failures++; $display("FAIL sb_empty: got %0d entries expected 0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
